// File: rtl/cpu_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_bridge
// Purpose  : Converts the multicycle core's level-held memory request into a
//            single registered valid/ready bus transaction, returns read data
//            with a one-cycle mem_resp, and bounds the wait for a bus
//            response with a timeout plus sticky error reporting.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_mem_bridge #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,            // asynchronous, active low
  // core side
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_rmask,
  input  logic [3:0]  mem_wmask,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  // bus request channel
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_we,
  output logic [31:0] bus_req_addr,
  output logic [3:0]  bus_req_wmask,
  output logic [31:0] bus_req_wdata,
  // bus response channel
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_rdata,
  input  logic        bus_rsp_err,
  // status
  output logic        err_sticky
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] w_cnt_inc;
  logic        bus_req_valid_q, bus_req_valid_d;
  logic        bus_req_we_q, bus_req_we_d;
  logic [31:0] bus_req_addr_q, bus_req_addr_d;
  logic [3:0]  bus_req_wmask_q, bus_req_wmask_d;
  logic [31:0] bus_req_wdata_q, bus_req_wdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        mem_resp_q, mem_resp_d;
  logic        err_sticky_q, err_sticky_d;
  logic        w_rd_req, w_wr_req;

  assign w_rd_req  = |mem_rmask;
  assign w_wr_req  = |mem_wmask;
  assign w_cnt_inc = cnt_q + c_cnt_one;

  // Next-state and next-output computation for the request/response sequencer
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bus_req_valid_d = bus_req_valid_q;
    bus_req_we_d    = bus_req_we_q;
    bus_req_addr_d  = bus_req_addr_q;
    bus_req_wmask_d = bus_req_wmask_q;
    bus_req_wdata_d = bus_req_wdata_q;
    err_sticky_d    = err_sticky_q;
    // mem_resp and mem_rdata are only non-zero for the single DONE cycle
    mem_resp_d      = 1'b0;
    mem_rdata_d     = 32'h0;

    case (state_q)
      ST_IDLE: begin
        if (w_rd_req || w_wr_req) begin
          bus_req_addr_d  = {mem_addr[31:2], 2'b00};
          bus_req_we_d    = w_wr_req;
          // a write takes priority when the core asserts both masks
          bus_req_wmask_d = w_wr_req ? mem_wmask : mem_rmask;
          bus_req_wdata_d = mem_wdata;
          bus_req_valid_d = 1'b1;
          if (w_rd_req && w_wr_req) begin
            err_sticky_d = 1'b1;
          end
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // a response coincident with the accept is illegal and ignored here
        if (bus_req_ready) begin
          bus_req_valid_d = 1'b0;
          cnt_d           = '0;
          state_d         = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (bus_rsp_valid) begin
          mem_resp_d = 1'b1;
          if (bus_rsp_err) begin
            err_sticky_d = 1'b1;
            mem_rdata_d  = 32'h0;
          end else if (bus_req_we_q) begin
            mem_rdata_d  = 32'h0;
          end else begin
            mem_rdata_d  = bus_rsp_rdata;
          end
          state_d = ST_DONE;
        end else if (w_cnt_inc == c_timeout) begin
          // counter saturates at the limit; the transaction is forced done
          cnt_d        = c_timeout;
          mem_resp_d   = 1'b1;
          mem_rdata_d  = 32'h0;
          err_sticky_d = 1'b1;
          state_d      = ST_DONE;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end

      ST_DONE: begin
        // core inputs are deliberately not sampled here: they still hold the
        // request that is completing in this cycle
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      bus_req_valid_q <= 1'b0;
      bus_req_we_q    <= 1'b0;
      bus_req_addr_q  <= 32'h0;
      bus_req_wmask_q <= 4'h0;
      bus_req_wdata_q <= 32'h0;
      mem_rdata_q     <= 32'h0;
      mem_resp_q      <= 1'b0;
      err_sticky_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bus_req_valid_q <= bus_req_valid_d;
      bus_req_we_q    <= bus_req_we_d;
      bus_req_addr_q  <= bus_req_addr_d;
      bus_req_wmask_q <= bus_req_wmask_d;
      bus_req_wdata_q <= bus_req_wdata_d;
      mem_rdata_q     <= mem_rdata_d;
      mem_resp_q      <= mem_resp_d;
      err_sticky_q    <= err_sticky_d;
    end
  end

  assign bus_req_valid = bus_req_valid_q;
  assign bus_req_we    = bus_req_we_q;
  assign bus_req_addr  = bus_req_addr_q;
  assign bus_req_wmask = bus_req_wmask_q;
  assign bus_req_wdata = bus_req_wdata_q;
  assign mem_rdata     = mem_rdata_q;
  assign mem_resp      = mem_resp_q;
  assign err_sticky    = err_sticky_q;

endmodule
`default_nettype wire
